// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial sequencer for the external 4-bit ripple adder.
// Takes a wide operand pair, feeds the adder LSB nibble first with a registered carry, and returns sum/cout/ovf.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | ready for an operand pair, adder inputs forced to 0
//   S_RUN  | one nibble per cycle through the adder, carry chained in r_carry
//   S_DONE | result presented on out_*, held until out_ready
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    // Only the upper W-4 bits of the partial sum are kept; the final nibble
    // comes straight from the adder on the last RUN edge.
    logic [W-5:0]  r_part;
    logic          r_carry;
    logic          r_a_msb;
    logic          r_b_msb;
    logic [IW-1:0] r_idx;
    logic          r_out_valid;
    logic [W-1:0]  r_out_sum;
    logic          r_out_cout;
    logic          r_out_ovf;

    logic [W-1:0]  w_sum_next;
    logic          w_run;
    logic          w_last;

    assign w_run      = (r_state == S_RUN);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_sum_next = {add_sum, r_part};

    assign add_a   = w_run ? r_a_sh[3:0] : 4'd0;
    assign add_b   = w_run ? r_b_sh[3:0] : 4'd0;
    assign add_cin = w_run ? r_carry : 1'b0;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_part      <= '0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= in_a;
                        r_b_sh  <= in_b;
                        r_part  <= '0;
                        r_carry <= in_cin;
                        r_a_msb <= in_a[W-1];
                        r_b_msb <= in_b[W-1];
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_part  <= w_sum_next[W-1:4];
                    r_carry <= add_cout;
                    r_a_sh  <= r_a_sh >> 4;
                    r_b_sh  <= r_b_sh >> 4;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_sum_next;
                        r_out_cout  <= add_cout;
                        r_out_ovf   <= (r_a_msb == r_b_msb) && (w_sum_next[W-1] != r_a_msb);
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural 4-bit adder.
// Expected values are hand-computed constants.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        busy;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] cap_a;
    logic [15:0] cap_b;
    logic [3:0]  cap_c;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Presents an operand pair for one edge, then scrambles the inputs.
    task automatic start(input logic [15:0] a, input logic [15:0] b, input logic c);
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // Records adder drive for the four RUN cycles; ends right after the DONE edge.
    task automatic run_nibbles(input string tag);
        cap_a = '0;
        cap_b = '0;
        cap_c = '0;
        for (int i = 0; i < 4; i++) begin
            cap_a = {cap_a[11:0], add_a};
            cap_b = {cap_b[11:0], add_b};
            cap_c = {cap_c[2:0], add_cin};
            if (i == 3) chkb({tag, "_valid_early"}, out_valid, 1'b0);
            tick();
        end
        chkb({tag, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chkb({tag, "_valid_drop"}, out_valid, 1'b0);
        chkb({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        #12;
        chkb("rst_out_valid", out_valid, 1'b0);
        chk ("rst_out_sum", out_sum, 16'h0000);
        chkb("rst_busy", busy, 1'b0);
        chk ("rst_add_a", {12'd0, add_a}, 16'h0000);
        rst = 1'b0;
        tick();
        chkb("idle_in_ready", in_ready, 1'b1);

        // basic add
        start(16'h1234, 16'h4321, 1'b0);
        chkb("basic_busy", busy, 1'b1);
        chkb("basic_in_ready_run", in_ready, 1'b0);
        run_nibbles("basic");
        chk ("basic_add_a_seq", cap_a, 16'h4321);
        chk ("basic_add_b_seq", cap_b, 16'h1234);
        chk ("basic_sum", out_sum, 16'h5555);
        chkb("basic_cout", out_cout, 1'b0);
        chkb("basic_ovf", out_ovf, 1'b0);
        chkb("basic_in_ready_done", in_ready, 1'b0);
        finish_op("basic");
        chk ("idle_add_a_zero", {12'd0, add_a}, 16'h0000);
        chk ("idle_sum_held", out_sum, 16'h5555);

        // carry ripple
        start(16'hFFFF, 16'h0001, 1'b0);
        run_nibbles("ripple");
        chk ("ripple_cin_seq", {12'd0, cap_c}, 16'h0007);
        chk ("ripple_sum", out_sum, 16'h0000);
        chkb("ripple_cout", out_cout, 1'b1);
        chkb("ripple_ovf", out_ovf, 1'b0);
        finish_op("ripple");

        // signed overflow, positive
        start(16'h7FFF, 16'h0001, 1'b0);
        run_nibbles("ovfp");
        chk ("ovfp_sum", out_sum, 16'h8000);
        chkb("ovfp_cout", out_cout, 1'b0);
        chkb("ovfp_ovf", out_ovf, 1'b1);
        finish_op("ovfp");

        // signed overflow, negative
        start(16'h8000, 16'h8000, 1'b0);
        run_nibbles("ovfn");
        chk ("ovfn_sum", out_sum, 16'h0000);
        chkb("ovfn_cout", out_cout, 1'b1);
        chkb("ovfn_ovf", out_ovf, 1'b1);
        finish_op("ovfn");

        // carry-in plus backpressure, with in_valid noise in RUN/DONE
        start(16'h0F0F, 16'h00F0, 1'b1);
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        run_nibbles("bp");
        for (int i = 0; i < 5; i++) begin
            chkb("bp_hold_valid", out_valid, 1'b1);
            chk ("bp_hold_sum", out_sum, 16'h1000);
            chkb("bp_hold_in_ready", in_ready, 1'b0);
            chkb("bp_hold_busy", busy, 1'b1);
            in_valid = ~in_valid;
            tick();
        end
        chk ("bp_sum", out_sum, 16'h1000);
        chkb("bp_cout", out_cout, 1'b0);
        chkb("bp_ovf", out_ovf, 1'b0);
        in_valid = 1'b0;
        finish_op("bp");
        chkb("bp_busy_idle", busy, 1'b0);

        // reset during second RUN cycle
        start(16'h1111, 16'h2222, 1'b0);
        tick();
        chkb("rstmid_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chkb("rstmid_out_valid", out_valid, 1'b0);
        chk ("rstmid_out_sum", out_sum, 16'h0000);
        chkb("rstmid_busy", busy, 1'b0);
        chk ("rstmid_add_b", {12'd0, add_b}, 16'h0000);
        chkb("rstmid_add_cin", add_cin, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chkb("rstmid_in_ready", in_ready, 1'b1);
        start(16'h0001, 16'h0002, 1'b0);
        run_nibbles("post_rst");
        chk ("post_rst_sum", out_sum, 16'h0003);
        chkb("post_rst_cout", out_cout, 1'b0);
        chkb("post_rst_ovf", out_ovf, 1'b0);
        finish_op("post_rst");

        // back-to-back, out_ready tied high: accepts 6 cycles apart
        out_ready = 1'b1;
        start(16'h1234, 16'hEDCC, 1'b0);
        run_nibbles("b2b1");
        chk ("b2b1_sum", out_sum, 16'h0000);
        chkb("b2b1_cout", out_cout, 1'b1);
        chkb("b2b1_ovf", out_ovf, 1'b0);
        chkb("b2b1_in_ready_done", in_ready, 1'b0);
        tick();
        chkb("b2b_in_ready_gap", in_ready, 1'b1);
        chkb("b2b_valid_gap", out_valid, 1'b0);
        start(16'h4000, 16'h4000, 1'b0);
        chkb("b2b2_busy", busy, 1'b1);
        run_nibbles("b2b2");
        chk ("b2b2_sum", out_sum, 16'h8000);
        chkb("b2b2_cout", out_cout, 1'b0);
        chkb("b2b2_ovf", out_ovf, 1'b1);
        tick();
        chkb("b2b2_in_ready_end", in_ready, 1'b1);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
